// File: rtl/topk_pkg.sv
// Shared constants, state encoding and small helpers for the top-k result streamer
// and the accumulator logic that feeds it.
package topk_pkg;

    localparam int TOPK_QUEUE_SIZE  = 8;
    localparam int TOPK_TDATA_WIDTH = 8;
    localparam int TOPK_ID_WIDTH    = 32;
    localparam int COUNT_WIDTH      = $clog2(TOPK_QUEUE_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_e;

    // Index width that stays legal for a single-slot table.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lowest_set_bit_encoder.sv
// Priority encoder: index of the lowest set bit of a mask, plus a flag that is high
// when that bit is the only one set (mask is one-hot).
module lowest_set_bit_encoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] mask,
    output logic [IDX_W-1:0] index,
    output logic             last_bit
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = IDX_W'(i);
            end
        end
    end

    assign last_bit = (mask != '0) && ((mask & (mask - WIDTH'(1))) == '0);

endmodule

// File: rtl/topk_result_streamer.sv
// Snapshots the top-k result table on start and streams the valid slots on M_AXIS in
// slot order. Define TOPK_RESULT_STREAMER_HEADER_EN to prefix each packet with a count beat.
module topk_result_streamer
    import topk_pkg::*;
#(
    parameter int QUEUE_SIZE  = TOPK_QUEUE_SIZE,
    parameter int TDATA_WIDTH = TOPK_TDATA_WIDTH,
    parameter int ID_WIDTH    = TOPK_ID_WIDTH
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            start,
    input  logic [ID_WIDTH*QUEUE_SIZE-1:0]  ids,
    input  logic [TDATA_WIDTH*QUEUE_SIZE-1:0] values,
    input  logic [QUEUE_SIZE-1:0]           valid,
    output logic                            busy,
    output logic                            done,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [TDATA_WIDTH+ID_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tlast
);

    localparam int IDX_W  = idx_width(QUEUE_SIZE);
    localparam int BEAT_W = TDATA_WIDTH + ID_WIDTH;

    state_e                  state_q, state_d;
    logic [QUEUE_SIZE-1:0]   pending_q, pending_d;
    logic [ID_WIDTH-1:0]     snap_id_q  [QUEUE_SIZE];
    logic [ID_WIDTH-1:0]     snap_id_d  [QUEUE_SIZE];
    logic [TDATA_WIDTH-1:0]  snap_val_q [QUEUE_SIZE];
    logic [TDATA_WIDTH-1:0]  snap_val_d [QUEUE_SIZE];

    logic [ID_WIDTH-1:0]     id_in  [QUEUE_SIZE];
    logic [TDATA_WIDTH-1:0]  val_in [QUEUE_SIZE];
    logic [IDX_W-1:0]        slot;
    logic                    pending_last;
    logic [QUEUE_SIZE-1:0]   slot_onehot;
    logic                    hs;

    genvar gi;
    generate
        for (gi = 0; gi < QUEUE_SIZE; gi++) begin : g_unpack
            assign id_in[gi]  = ids[(gi+1)*ID_WIDTH-1 -: ID_WIDTH];
            assign val_in[gi] = values[(gi+1)*TDATA_WIDTH-1 -: TDATA_WIDTH];
        end
    endgenerate

    lowest_set_bit_encoder #(
        .WIDTH (QUEUE_SIZE),
        .IDX_W (IDX_W)
    ) u_slot_enc (
        .mask     (pending_q),
        .index    (slot),
        .last_bit (pending_last)
    );

    assign slot_onehot = QUEUE_SIZE'(1) << slot;
    assign hs          = m_axis_tvalid && m_axis_tready;

`ifdef TOPK_RESULT_STREAMER_HEADER_EN
    localparam int CNT_W = $clog2(QUEUE_SIZE + 1);
    logic [CNT_W-1:0] hdr_count;

    // pending is untouched while in HDR, so its popcount equals the snapshot's.
    always_comb begin
        hdr_count = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            hdr_count = hdr_count + CNT_W'(pending_q[i]);
        end
    end
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                snap_id_q[i]  <= '0;
                snap_val_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            snap_id_q  <= snap_id_d;
            snap_val_q <= snap_val_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        snap_id_d  = snap_id_q;
        snap_val_d = snap_val_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pending_d  = valid;
                    snap_id_d  = id_in;
                    snap_val_d = val_in;
`ifdef TOPK_RESULT_STREAMER_HEADER_EN
                    state_d    = HDR;
`else
                    state_d    = (valid != '0) ? SEND : FIN;
`endif
                end
            end
            HDR: begin
                if (hs) begin
                    state_d = (pending_q != '0) ? SEND : FIN;
                end
            end
            SEND: begin
                if (hs) begin
                    pending_d = pending_q & ~slot_onehot;
                    if (pending_last) begin
                        state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on registered state, never on tready.
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        case (state_q)
`ifdef TOPK_RESULT_STREAMER_HEADER_EN
            HDR: begin
                busy          = 1'b1;
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = BEAT_W'(hdr_count);
                m_axis_tlast  = (pending_q == '0);
            end
`endif
            SEND: begin
                busy          = 1'b1;
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = {snap_val_q[slot], snap_id_q[slot]};
                m_axis_tlast  = pending_last;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

endmodule
